// File: rtl/axi_master_ctrl_if.sv
// Bus bundle between the switch-driven AXI-lite style master and its slave.
// Address and data are 4 bits wide; each channel carries a single beat.
interface axi_master_ctrl_if;
  logic       ms_arvalid;
  logic [3:0] SWM_arADDR;
  logic       sm_arready;
  logic       ms_rready;
  logic       sm_rvalid;
  logic       ms_awvalid;
  logic       sm_awready;
  logic       ms_wvalid;
  logic [3:0] SWM_wdata;
  logic       sm_wready;

  modport master (
    output ms_arvalid,
    output SWM_arADDR,
    input  sm_arready,
    output ms_rready,
    input  sm_rvalid,
    output ms_awvalid,
    input  sm_awready,
    output ms_wvalid,
    output SWM_wdata,
    input  sm_wready
  );

  modport slave (
    input  ms_arvalid,
    input  SWM_arADDR,
    output sm_arready,
    input  ms_rready,
    output sm_rvalid,
    input  ms_awvalid,
    output sm_awready,
    input  ms_wvalid,
    input  SWM_wdata,
    output sm_wready
  );
endinterface

// File: rtl/axi_master_ctrl.sv
// Single-beat bus master driven by switches. A read walks AR -> R; a write walks
// AR -> AW -> W -> R so the written location is read back. Each wait state aborts
// to IDLE with a sticky err after TIMEOUT cycles without its handshake.
module axi_master_ctrl #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_rd,
  input  logic                     cmd_wr,
  input  logic [3:0]               sw_addr,
  input  logic [3:0]               sw_data,
  axi_master_ctrl_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               txn_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAr   = 3'd1;
  localparam logic [2:0] StR    = 3'd2;
  localparam logic [2:0] StAw   = 3'd3;
  localparam logic [2:0] StW    = 3'd4;

  // Wait-counter value on which a stalled state gives up.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] addr_q, data_q;
  logic       is_wr_q;
  logic       err_q, done_q;
  logic [7:0] txn_q;

  logic accept;
  logic hs;
  logic abort;
  logic complete;

  assign accept   = (state_q == StIdle) && (cmd_rd || cmd_wr);
  assign abort    = (state_q != StIdle) && !hs && (wait_q == TimeoutLast);
  assign complete = (state_q == StR) && bus.sm_rvalid;

  // Handshake input that lets the current wait state advance.
  always_comb begin
    hs = 1'b0;
    unique case (state_q)
      StAr:    hs = bus.sm_arready;
      StAw:    hs = bus.sm_awready;
      StW:     hs = bus.sm_wready;
      StR:     hs = bus.sm_rvalid;
      default: hs = 1'b0;
    endcase
  end

  // Next state; a handshake takes precedence over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      if (accept) state_d = StAr;
    end else if (hs) begin
      unique case (state_q)
        StAr:    state_d = is_wr_q ? StAw : StR;
        StAw:    state_d = StW;
        StW:     state_d = StR;
        default: state_d = StIdle;
      endcase
    end else if (abort) begin
      state_d = StIdle;
    end
  end

  // Wait counter restarts on every state change and runs only while waiting.
  always_comb begin
    wait_d = 8'd0;
    if (state_d == state_q && state_q != StIdle) wait_d = wait_q + 8'd1;
  end

  // State, wait counter and completion bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 8'd0;
      done_q  <= 1'b0;
      txn_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= complete;
      if (complete) txn_q <= txn_q + 8'd1;
    end
  end

  // Command capture; address/data hold for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 4'd0;
      data_q  <= 4'd0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= sw_addr;
      data_q  <= sw_data;
      is_wr_q <= cmd_wr && !cmd_rd;
      err_q   <= 1'b0;
    end else if (abort) begin
      err_q   <= 1'b1;
    end
  end

  // Outputs decode only registered state and datapath.
  assign bus.ms_arvalid = (state_q == StAr);
  assign bus.ms_rready  = (state_q == StR);
  assign bus.ms_awvalid = (state_q == StAw) || (state_q == StW);
  assign bus.ms_wvalid  = (state_q == StW);
  assign bus.SWM_arADDR = addr_q;
  assign bus.SWM_wdata  = data_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign err            = err_q;
  assign txn_count      = txn_q;

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Directed bench for axi_master_ctrl with TIMEOUT=10 and a hand-driven slave.
module tb_axi_master_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_rd, cmd_wr;
  logic [3:0] sw_addr, sw_data;
  logic       busy, done, err;
  logic [7:0] txn_count;

  int n_cmp = 0;
  int n_err = 0;

  axi_master_ctrl_if bus ();

  axi_master_ctrl #(.TIMEOUT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_rd    (cmd_rd),
    .cmd_wr    (cmd_wr),
    .sw_addr   (sw_addr),
    .sw_data   (sw_data),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read with ar_wait cycles of arvalid before arready; rvalid right after.
  task automatic run_read(input logic [3:0] addr, input int ar_wait);
    cmd_rd = 1'b1;
    sw_addr = addr;
    tick();
    cmd_rd = 1'b0;
    repeat (ar_wait) tick();
    bus.sm_arready = 1'b1;
    tick();
    bus.sm_arready = 1'b0;
    bus.sm_rvalid = 1'b1;
    tick();
    bus.sm_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    int dones;
    reset = 1'b1;
    cmd_rd = 1'b0;
    cmd_wr = 1'b0;
    sw_addr = 4'd0;
    sw_data = 4'd0;
    bus.sm_arready = 1'b0;
    bus.sm_rvalid  = 1'b0;
    bus.sm_awready = 1'b0;
    bus.sm_wready  = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_txn", {24'd0, txn_count}, 32'd0);
    chk("rst_valids", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'd0);
    chk("rst_addr", {28'd0, bus.SWM_arADDR}, 32'd0);
    reset = 1'b0;

    // Basic read of address 5.
    cmd_rd = 1'b1;
    sw_addr = 4'd5;
    tick();
    cmd_rd = 1'b0;
    chk("rd_arvalid", {31'd0, bus.ms_arvalid}, 32'd1);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_addr", {28'd0, bus.SWM_arADDR}, 32'd5);
    bus.sm_arready = 1'b1;
    tick();
    bus.sm_arready = 1'b0;
    chk("rd_arvalid_drop", {31'd0, bus.ms_arvalid}, 32'd0);
    chk("rd_rready", {31'd0, bus.ms_rready}, 32'd1);
    chk("rd_no_done_yet", {31'd0, done}, 32'd0);
    bus.sm_rvalid = 1'b1;
    tick();
    bus.sm_rvalid = 1'b0;
    chk("rd_done", {31'd0, done}, 32'd1);
    chk("rd_txn", {24'd0, txn_count}, 32'd1);
    chk("rd_idle", {30'd0, busy, bus.ms_rready}, 32'd0);
    tick();
    chk("rd_done_pulse", {31'd0, done}, 32'd0);

    // Write 9 to address 3 with a colliding read command mid-transaction.
    cmd_wr = 1'b1;
    sw_addr = 4'd3;
    sw_data = 4'd9;
    tick();
    cmd_wr = 1'b0;
    chk("wr_ar", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'b1000);
    chk("wr_data", {28'd0, bus.SWM_wdata}, 32'd9);
    bus.sm_arready = 1'b1;
    tick();
    bus.sm_arready = 1'b0;
    chk("wr_aw", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'b0010);
    cmd_rd = 1'b1;
    sw_addr = 4'd7;
    sw_data = 4'd1;
    bus.sm_awready = 1'b1;
    tick();
    bus.sm_awready = 1'b0;
    cmd_rd = 1'b0;
    chk("wr_w", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'b0011);
    chk("busy_addr_hold", {28'd0, bus.SWM_arADDR}, 32'd3);
    chk("busy_data_hold", {28'd0, bus.SWM_wdata}, 32'd9);
    bus.sm_wready = 1'b1;
    tick();
    bus.sm_wready = 1'b0;
    chk("wr_r", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'b0100);
    bus.sm_rvalid = 1'b1;
    tick();
    bus.sm_rvalid = 1'b0;
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_txn", {24'd0, txn_count}, 32'd2);
    tick();
    chk("wr_single_done", {30'd0, done, busy}, 32'd0);

    // Timeout: arready never comes.
    cmd_rd = 1'b1;
    sw_addr = 4'd1;
    tick();
    cmd_rd = 1'b0;
    n = 0;
    dones = 0;
    for (int i = 0; i < 30 && bus.ms_arvalid; i++) begin
      n++;
      tick();
      if (done) dones++;
    end
    chk("to_arvalid_cycles", n, 32'd10);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_no_done", dones, 32'd0);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_txn", {24'd0, txn_count}, 32'd2);
    tick();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    cmd_rd = 1'b1;
    tick();
    chk("to_err_clear", {31'd0, err}, 32'd0);
    cmd_rd = 1'b0;
    bus.sm_arready = 1'b1;
    tick();
    bus.sm_arready = 1'b0;
    bus.sm_rvalid = 1'b1;
    tick();
    bus.sm_rvalid = 1'b0;
    chk("to_recover_txn", {24'd0, txn_count}, 32'd3);

    // Simultaneous read and write requests run as a read.
    cmd_rd = 1'b1;
    cmd_wr = 1'b1;
    sw_addr = 4'd4;
    tick();
    cmd_rd = 1'b0;
    cmd_wr = 1'b0;
    bus.sm_arready = 1'b1;
    tick();
    bus.sm_arready = 1'b0;
    chk("both_is_read", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'b0100);
    bus.sm_rvalid = 1'b1;
    tick();
    bus.sm_rvalid = 1'b0;
    chk("both_txn", {24'd0, txn_count}, 32'd4);

    // arready lands on the last wait cycle: handshake wins.
    run_read(4'd6, 9);
    chk("hs_on_to_done", {31'd0, done}, 32'd1);
    chk("hs_on_to_err", {31'd0, err}, 32'd0);
    chk("hs_on_to_txn", {24'd0, txn_count}, 32'd5);

    // Reset while in W with wready present.
    cmd_wr = 1'b1;
    sw_addr = 4'd11;
    sw_data = 4'd12;
    tick();
    cmd_wr = 1'b0;
    bus.sm_arready = 1'b1;
    tick();
    bus.sm_arready = 1'b0;
    bus.sm_awready = 1'b1;
    tick();
    bus.sm_awready = 1'b0;
    chk("mid_w", {31'd0, bus.ms_wvalid}, 32'd1);
    bus.sm_wready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.sm_wready = 1'b0;
    chk("mrst_valids", {28'd0, bus.ms_arvalid, bus.ms_rready, bus.ms_awvalid, bus.ms_wvalid},
        32'd0);
    chk("mrst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("mrst_data", {24'd0, bus.SWM_arADDR, bus.SWM_wdata}, 32'd0);
    chk("mrst_txn", {24'd0, txn_count}, 32'd0);
    tick();
    chk("mrst_no_done", {31'd0, done}, 32'd0);

    // 256 back-to-back reads wrap the counter.
    dones = 0;
    for (int i = 0; i < 256; i++) begin
      run_read(4'(i), 0);
      if (done) dones++;
      if (i == 254) chk("wrap_255", {24'd0, txn_count}, 32'd255);
    end
    chk("wrap_dones", dones, 32'd256);
    chk("wrap_zero", {24'd0, txn_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
